// File: rtl/sqrt_core_arbiter.sv
// Round-robin arbiter sharing one CORDIC square-root core among N_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT (done or timeout) -> RESP.
module sqrt_core_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [18*N_REQ-1:0]       req_x_i,
  input  logic [18*N_REQ-1:0]       req_y_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic signed [17:0]        rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      core_start_o,
  output logic signed [17:0]        core_x_o,
  output logic signed [17:0]        core_y_o,
  input  logic signed [17:0]        core_sqrt_i,
  input  logic                      core_done_i,
  output logic                      busy_o
);

  localparam int unsigned DW = 18;
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                state_q;
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         last_grant_q;
  logic [TW-1:0]         timer_q;
  logic [N_REQ-1:0]      req_ready_q;
  logic [N_REQ-1:0]      rsp_valid_q;
  logic signed [DW-1:0]  rsp_data_q;
  logic                  rsp_err_q;
  logic                  core_start_q;
  logic signed [DW-1:0]  core_x_q;
  logic signed [DW-1:0]  core_y_q;
  logic                  busy_q;

  logic [GW-1:0]         grant_d;
  logic                  found;

  // Round-robin pick: first valid requester after the last one served.
  always_comb begin
    int unsigned idx;
    grant_d = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last_grant_q) + i) % N_REQ;
      if (!found && req_valid_i[GW'(idx)]) begin
        grant_d = GW'(idx);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      timer_q      <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      core_start_q <= 1'b0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_q      <= grant_d;
            core_x_q     <= req_x_i[DW*32'(grant_d) +: DW];
            core_y_q     <= req_y_i[DW*32'(grant_d) +: DW];
            core_start_q <= 1'b1;
            req_ready_q  <= N_REQ'(1) << grant_d;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last timer tick still counts as success.
          if (core_done_i) begin
            rsp_data_q  <= core_sqrt_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= N_REQ'(1) << grant_q;
            state_q     <= S_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= N_REQ'(1) << grant_q;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: begin
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign core_start_o = core_start_q;
  assign core_x_o     = core_x_q;
  assign core_y_o     = core_y_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/sqrt_core_arbiter.md
SQRT_CORE_ARBITER -- requirements
Module: sqrt_core_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one CORDIC square-root core (2..8).
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles before a transaction is aborted (>=2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester request; held with operands until its req_ready pulse.
REQ-006 req_x  input  18*N_REQ  signed operand x, slice i for requester i.
REQ-007 req_y  input  18*N_REQ  signed operand y, slice i for requester i.
REQ-008 req_ready  output  N_REQ  one-hot, one-cycle accept pulse.
REQ-009 rsp_valid  output  N_REQ  one-hot, one-cycle result pulse to the granted requester.
REQ-010 rsp_data  output  18  signed result; valid while any rsp_valid bit is high.
REQ-011 rsp_err  output  1  timeout flag; valid with rsp_valid.
REQ-012 core_start  output  1  one-cycle start to the sqrt core.
REQ-013 core_x, core_y  output  18 each  signed operands to the core.
REQ-014 core_sqrt  input  18  core result.
REQ-015 core_done  input  1  core completion.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-018 IDLE: any req_valid high at a rising edge -> select grant g round-robin, searching from last_grant+1 modulo N_REQ; latch req_x[g], req_y[g] into core_x/core_y; go ISSUE.
REQ-019 ISSUE (exactly one cycle): core_start=1, req_ready[g]=1; clear timer; go WAIT.
REQ-020 core_x/core_y hold the latched operands from ISSUE through the end of WAIT.
REQ-021 WAIT: core_done=1 -> register core_sqrt into rsp_data, rsp_err=0, go RESP.
REQ-022 WAIT: no core_done -> timer increments; timer reaching TIMEOUT-1 without core_done -> rsp_data=0, rsp_err=1, go RESP.
REQ-023 core_done high and timer at TIMEOUT-1 in the same cycle -> core_done wins (rsp_err=0).
REQ-024 RESP (exactly one cycle): rsp_valid[g]=1; last_grant<=g; go IDLE.
REQ-025 core_done outside WAIT is ignored; no state, data or error change.
REQ-026 req_valid deasserted before a grant -> no grant issued to that requester.
REQ-027 Minimum spacing between consecutive core_start pulses is core latency + 3 cycles; no request starves while asserted (served within N_REQ transactions).
REQ-028 rsp_data and rsp_err hold their values until the next RESP entry.

Reset
REQ-029 rst high, at any time including mid-WAIT: state=IDLE; req_ready, rsp_valid, core_start, busy, rsp_err = 0; rsp_data, core_x, core_y, timer = 0; last_grant=N_REQ-1 (requester 0 has first priority).
REQ-030 A transaction in flight at reset is dropped with no rsp_valid; a later core_done is ignored per REQ-025.

Verification
REQ-031 Requester 0 sends (300,400); core model returns 500 after 10 cycles -> req_ready[0] pulse, one core_start with core_x=300, core_y=400, then rsp_valid[0]=1, rsp_data=500, rsp_err=0.
REQ-032 All four requesters assert simultaneously after reset with x=1000,0,-359,1000 -> grants in order 0,1,2,3; each rsp_valid[i] carries that requester's model result.
REQ-033 Requesters 0 and 2 held continuously -> grants alternate 0,2,0,2; requesters 1,3 never pulsed.
REQ-034 Core model never asserts done -> rsp_valid[g]=1 exactly TIMEOUT WAIT cycles after core_start, rsp_err=1, rsp_data=0; next request then serviced normally.
REQ-035 rst asserted 3 cycles into WAIT, core_done pulsed afterwards -> all outputs 0 per REQ-029, no rsp_valid; next request from requester 1 alone granted normally.
REQ-036 core_done pulsed while IDLE and during RESP -> no rsp_valid, rsp_data unchanged.
